// File: rtl/issue_sequencer.sv
// rtl/issue_sequencer.sv - registered dual-issue sequencer that serialises dependent instruction pairs
module issue_sequencer #(
    parameter int PKT_W = 120,
    parameter int CNT_W = 16
) (
    input  logic             is_i_clk,
    input  logic             is_i_rst,
    input  logic             is_i_valid,
    input  logic             is_i_split,
    input  logic [PKT_W-1:0] is_i_pkt_1,
    input  logic [PKT_W-1:0] is_i_pkt_2,
    input  logic             is_i_flush,
    input  logic             is_i_stall_dn,
    output logic             is_o_ready,
    output logic             is_o_valid_1,
    output logic             is_o_valid_2,
    output logic [PKT_W-1:0] is_o_pkt_1,
    output logic [PKT_W-1:0] is_o_pkt_2,
    output logic [CNT_W-1:0] is_o_split_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PAIR,
        ST_SLOT1,
        ST_SLOT2
    } state_t;

    state_t           state_q, state_d;
    logic [PKT_W-1:0] pkt1_q, pkt1_d;
    logic [PKT_W-1:0] pkt2_q, pkt2_d;
    logic [PKT_W-1:0] held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    // Decode is blocked while slot 2 of a split pair is still waiting to issue.
    assign is_o_ready = !is_i_rst && !is_i_stall_dn && !is_i_flush && (state_q != ST_SLOT1);
    assign accept     = is_i_valid && is_o_ready;

    // Valids derive from the state register so an async reset clears them at once.
    assign is_o_valid_1   = (state_q != ST_EMPTY);
    assign is_o_valid_2   = (state_q == ST_PAIR);
    assign is_o_pkt_1     = pkt1_q;
    assign is_o_pkt_2     = pkt2_q;
    assign is_o_split_cnt = cnt_q;

    // Next-state and datapath loads: flush beats stall, stall beats advance.
    always_comb begin
        state_d = state_q;
        pkt1_d  = pkt1_q;
        pkt2_d  = pkt2_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        if (is_i_flush) begin
            state_d = ST_EMPTY;
            held_d  = '0;
        end else if (!is_i_stall_dn) begin
            if (state_q == ST_SLOT1) begin
                state_d = ST_SLOT2;
                pkt1_d  = held_q;
            end else if (accept && !is_i_split) begin
                state_d = ST_PAIR;
                pkt1_d  = is_i_pkt_1;
                pkt2_d  = is_i_pkt_2;
            end else if (accept) begin
                state_d = ST_SLOT1;
                pkt1_d  = is_i_pkt_1;
                held_d  = is_i_pkt_2;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // State, packet, held-slot and counter registers.
    always_ff @(posedge is_i_clk or posedge is_i_rst) begin
        if (is_i_rst) begin
            state_q <= ST_EMPTY;
            pkt1_q  <= '0;
            pkt2_q  <= '0;
            held_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt1_q  <= pkt1_d;
            pkt2_q  <= pkt2_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_issue_sequencer.sv
// tb/tb_issue_sequencer.sv - self-checking bench for issue_sequencer against an issue-stream model
module tb_issue_sequencer;

    localparam int PKT_W = 120;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             valid = 1'b0;
    logic             split = 1'b0;
    logic             flush = 1'b0;
    logic             stall = 1'b0;
    logic [PKT_W-1:0] pin1 = '0;
    logic [PKT_W-1:0] pin2 = '0;

    logic             ready, v1, v2;
    logic [PKT_W-1:0] po1, po2;
    logic [15:0]      cnt;
    logic             ready_s, v1_s, v2_s;
    logic [PKT_W-1:0] po1_s, po2_s;
    logic [1:0]       cnt_s;

    int errors = 0;
    int checks = 0;

    // Model: issued lanes, a queue of instructions still owed to lane 1, total split count.
    logic             m_v1, m_v2;
    logic [PKT_W-1:0] m_p1, m_p2;
    logic [PKT_W-1:0] owed[$];
    int               m_splits;

    issue_sequencer #(.PKT_W(PKT_W), .CNT_W(16)) dut (
        .is_i_clk(clk), .is_i_rst(rst), .is_i_valid(valid), .is_i_split(split),
        .is_i_pkt_1(pin1), .is_i_pkt_2(pin2), .is_i_flush(flush), .is_i_stall_dn(stall),
        .is_o_ready(ready), .is_o_valid_1(v1), .is_o_valid_2(v2),
        .is_o_pkt_1(po1), .is_o_pkt_2(po2), .is_o_split_cnt(cnt)
    );

    issue_sequencer #(.PKT_W(PKT_W), .CNT_W(2)) dut_small (
        .is_i_clk(clk), .is_i_rst(rst), .is_i_valid(valid), .is_i_split(split),
        .is_i_pkt_1(pin1), .is_i_pkt_2(pin2), .is_i_flush(flush), .is_i_stall_dn(stall),
        .is_o_ready(ready_s), .is_o_valid_1(v1_s), .is_o_valid_2(v2_s),
        .is_o_pkt_1(po1_s), .is_o_pkt_2(po2_s), .is_o_split_cnt(cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] rnd_pkt();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[PKT_W-1:0];
    endfunction

    function automatic logic model_ready();
        return !rst && !stall && !flush && (owed.size() == 0);
    endfunction

    task automatic model_reset();
        m_v1 = 1'b0; m_v2 = 1'b0; m_p1 = '0; m_p2 = '0;
        owed.delete();
        m_splits = 0;
    endtask

    task automatic check_outputs(input string where);
        int sat;
        sat = (m_splits > 3) ? 3 : m_splits;
        chk({where, ".valid_1"}, 128'(v1), 128'(m_v1));
        chk({where, ".valid_2"}, 128'(v2), 128'(m_v2));
        chk({where, ".pkt_1"}, 128'(po1), 128'(m_p1));
        chk({where, ".pkt_2"}, 128'(po2), 128'(m_p2));
        chk({where, ".split_cnt"}, 128'(cnt), 128'(m_splits));
        chk({where, ".small_cnt"}, 128'(cnt_s), 128'(sat));
        chk({where, ".small_valid_1"}, 128'(v1_s), 128'(m_v1));
    endtask

    // One clock: drive inputs, check ready before the edge, advance model, check outputs after.
    task automatic step(input string tag, input logic iv, input logic isp, input logic ifl,
                        input logic ist, input logic [PKT_W-1:0] a, input logic [PKT_W-1:0] b);
        logic acc;
        valid = iv; split = isp; flush = ifl; stall = ist; pin1 = a; pin2 = b;
        #1;
        chk({tag, ".ready"}, 128'(ready), 128'(model_ready()));
        acc = iv && model_ready();
        @(posedge clk);
        if (ifl) begin
            m_v1 = 1'b0; m_v2 = 1'b0;
            owed.delete();
        end else if (!ist) begin
            if (owed.size() != 0) begin
                m_p1 = owed.pop_front(); m_v1 = 1'b1; m_v2 = 1'b0;
            end else if (acc && !isp) begin
                m_p1 = a; m_p2 = b; m_v1 = 1'b1; m_v2 = 1'b1;
            end else if (acc) begin
                m_p1 = a; owed.push_back(b); m_v1 = 1'b1; m_v2 = 1'b0;
                m_splits++;
            end else begin
                m_v1 = 1'b0; m_v2 = 1'b0;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset.ready", 128'(ready), 128'(0));
        check_outputs("reset");
        rst = 1'b0;
    endtask

    logic [PKT_W-1:0] pa, pb, pc, pd;

    initial begin
        model_reset();
        valid = 1'b0; split = 1'b0; flush = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Independent pairs back to back.
        pa = rnd_pkt(); pb = rnd_pkt(); pc = rnd_pkt(); pd = rnd_pkt();
        step("pair_ab", 1, 0, 0, 0, pa, pb);
        step("pair_cd", 1, 0, 0, 0, pc, pd);

        // Split E/F then G/H held valid until accepted.
        pa = rnd_pkt(); pb = rnd_pkt(); pc = rnd_pkt(); pd = rnd_pkt();
        step("split_ef", 1, 1, 0, 0, pa, pb);
        step("gh_wait", 1, 0, 0, 0, pc, pd);
        step("gh_take", 1, 0, 0, 0, pc, pd);
        chk("split_ef.count_one", 128'(cnt), 128'(1));

        // Split with three stall cycles in SLOT1.
        pa = rnd_pkt(); pb = rnd_pkt();
        step("stall_split", 1, 1, 0, 0, pa, pb);
        for (int i = 0; i < 3; i++) step("stall_hold", 1, 0, 0, 1, pc, pd);
        step("stall_f", 1, 0, 0, 0, pc, pd);
        step("stall_gh", 1, 0, 0, 0, pc, pd);

        // Flush while slot 2 is held: it must never issue.
        pa = rnd_pkt(); pb = rnd_pkt();
        step("flush_split", 1, 1, 0, 0, pa, pb);
        step("flush_kill", 1, 0, 1, 0, pc, pd);
        step("flush_after", 0, 0, 0, 0, pc, pd);
        step("flush_next", 1, 0, 0, 0, pa, pb);

        // Flush and stall together with a valid pair.
        step("flush_stall", 1, 0, 1, 1, pc, pd);
        step("flush_stall_idle", 0, 0, 0, 0, pc, pd);

        // Asynchronous reset in the SLOT1 cycle.
        pa = rnd_pkt(); pb = rnd_pkt();
        step("async_split", 1, 1, 0, 0, pa, pb);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async.ready", 128'(ready), 128'(0));
        check_outputs("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("async_no_f", 0, 0, 0, 0, pc, pd);

        // Four splits on a two-bit counter saturate at 3.
        for (int i = 0; i < 4; i++) begin
            step("sat_split", 1, 1, 0, 0, rnd_pkt(), rnd_pkt());
            step("sat_slot2", 0, 0, 0, 0, pc, pd);
        end
        chk("sat.small_cnt", 128'(cnt_s), 128'(3));

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(9) < 7), ($urandom_range(9) < 4),
                 ($urandom_range(9) == 0), ($urandom_range(9) < 2),
                 rnd_pkt(), rnd_pkt());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_sequencer.md
# issue_sequencer

Registered dual-issue sequencer placed directly downstream of the dependency chooser and upstream of the ID/EX pipeline register. Each cycle it accepts one decoded instruction pair plus a split flag. Independent pairs go out together, both lanes valid. Dependent (split) pairs are serialised: slot 1 issues first, then slot 2 in the following issue cycle, and the block back-pressures decode while it is still holding slot 2.

## Interface
Parameters:
- PKT_W, 120, width of one opaque decoded-instruction bundle (pc, imm, funct, opcode, jal_addr, rs/rt data, rd/rs/rt addresses, control bits)
- CNT_W, 16, width of the split-event counter

Ports:
- is_i_clk  in  1  clock; all state updates on rising edge
- is_i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- is_i_valid  in  1  decode presents a pair this cycle
- is_i_split  in  1  pair has an intra-pair dependency; slot 2 must issue after slot 1
- is_i_pkt_1  in  PKT_W  older instruction (slot 1)
- is_i_pkt_2  in  PKT_W  younger instruction (slot 2)
- is_i_flush  in  1  squash: branch/jr redirect
- is_i_stall_dn  in  1  ID/EX cannot accept; hold outputs
- is_o_ready  out  1  pair accepted this cycle when is_i_valid=1 (combinational)
- is_o_valid_1  out  1  lane 1 carries an instruction
- is_o_valid_2  out  1  lane 2 carries an instruction
- is_o_pkt_1  out  PKT_W  lane 1 bundle (registered)
- is_o_pkt_2  out  PKT_W  lane 2 bundle (registered)
- is_o_split_cnt  out  CNT_W  number of split pairs accepted, saturating

## Operation
- States: EMPTY (no valid outputs), PAIR (both lanes valid), SLOT1 (lane 1 = slot 1, slot 2 held internally), SLOT2 (lane 1 = held slot 2).
- Split pairs always issue on lane 1 only; is_o_valid_2=0 in SLOT1 and SLOT2. This keeps program order on a single lane.
- is_o_ready = !is_i_stall_dn && !is_i_flush && (state != SLOT1).
- accept = is_i_valid && is_o_ready.
- Priority per edge: reset > flush > stall > advance.
- Flush: next state EMPTY; both valids 0; held slot 2 discarded; no pair accepted that cycle. The counter is not cleared.
- Stall (is_i_stall_dn=1, no flush): state, held packet, outputs and counter all hold.
- Advance (no stall, no flush):
  - SLOT1 -> SLOT2: is_o_pkt_1 = held, valid_1=1, valid_2=0.
  - Any other state with accept and !is_i_split -> PAIR: pkt_1/pkt_2 loaded, both valids 1.
  - Any other state with accept and is_i_split -> SLOT1: is_o_pkt_1 = is_i_pkt_1, held = is_i_pkt_2, valid_1=1, valid_2=0. The counter increments unless already all-ones.
  - Any other state without accept -> EMPTY, valids 0.
- Packet registers load only on the transitions above; otherwise they keep their value. Packet contents are meaningful only while the matching valid is 1.
- Reset values: state EMPTY; is_o_valid_1/2=0; is_o_pkt_1/2=0; held=0; is_o_split_cnt=0. While is_i_rst=1, is_o_ready=0 (the state is forced to EMPTY, and ready is additionally gated low during reset).

## Timing
- Independent pair accepted at edge N: both lanes valid after N (1-cycle latency).
- Split pair accepted at edge N: slot 1 is valid on lane 1 after N, and slot 2 after N+1 (absent stall). is_o_ready is 0 for the cycle between N and N+1.
- Sustained throughput: 2 instructions/cycle for independent pairs, 1 instruction/cycle while splitting.
- Each stall cycle extends the current output by exactly one cycle. No instruction is duplicated or lost.
- Flush takes effect at the next edge. Outputs are invalid from the cycle after the flush edge until a new pair is accepted.
- Reset asserted mid-split drops the held slot 2 asynchronously. Outputs go invalid immediately, without waiting for a clock edge.
- Flush and stall in the same cycle: flush wins.
- Counter at all-ones stays all-ones on further splits.

## Test plan
- Reset, then independent pairs A/B and C/D on consecutive cycles -> A/B valid on both lanes at edge 1, C/D at edge 2, is_o_ready constantly 1, count 0.
- Split pair E/F followed by independent G/H held valid -> E on lane 1 at edge 1, ready=0, F on lane 1 at edge 2, G/H on both lanes at edge 3, count 1.
- Split pair, stall_dn high for 3 cycles while in SLOT1 -> E held 4 cycles, F follows exactly once, no G/H accepted until stall clears.
- Split pair then flush in the SLOT1 cycle -> valids 0 next cycle, F never issues, next pair issues normally, count stays 1.
- Flush and stall asserted together with is_i_valid=1 -> pair not accepted, outputs invalid after the edge.
- CNT_W=2, four split pairs -> count 1,2,3,3.
- Reset asserted mid-split -> outputs, held packet and count zero without a clock edge.
